lbp_code_gen: RTL and testbench

- Downstream consumer of the four diagonal bilinear-interpolation instances (45/135/225/315 deg) in the LBP datapath.
- Takes the centre pixel, the four axial neighbours and the four interpolated Q8.16 diagonal samples, and delays the raw pixels to match interpolation latency.
- Rounds and saturates the interpolated samples to 8 bits, thresholds all eight neighbours against the centre, and emits an 8-bit LBP code per pixel with valid and end-of-frame pulse.

---
 rtl/lbp_code_gen.sv | 131 +++++++++++++
 tb/tb_lbp_code_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lbp_code_gen.sv
// LBP code generator: aligns raw centre/axial pixels with the interpolated
// diagonals, rounds/saturates them, thresholds against the centre and counts frame pixels.
module lbp_code_gen #(
   parameter int INTERP_LAT = 3,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [7:0]  center_i,
   input  logic [7:0]  p0_i,
   input  logic [7:0]  p90_i,
   input  logic [7:0]  p180_i,
   input  logic [7:0]  p270_i,
   input  logic [23:0] i45_i,
   input  logic [23:0] i135_i,
   input  logic [23:0] i225_i,
   input  logic [23:0] i315_i,
   output logic [7:0]  code_o,
   output logic        valid_o,
   output logic        done_o
);

   localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);

   typedef struct packed {
      logic       vld;
      logic [7:0] ctr;
      logic [7:0] a0;
      logic [7:0] a90;
      logic [7:0] a180;
      logic [7:0] a270;
   } raw_t;

   // Q8.16 -> 8 bit, round half up, clamp at 255
   function automatic logic [7:0] round_sat(input logic [23:0] x);
      logic [8:0] r;
      r = 9'(({1'b0, x} + 25'h0008000) >> 16);
      return r[8] ? 8'hFF : r[7:0];
   endfunction

   raw_t dl_q [INTERP_LAT];
   raw_t dl_d [INTERP_LAT];
   raw_t tap;

   logic            sa_vld_q, sa_vld_d;
   logic [7:0]      sa_ctr_q, sa_ctr_d;
   logic [7:0][7:0] sa_nb_q, sa_nb_d;

   logic [7:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      dl_d[0] = '{vld: valid_i, ctr: center_i, a0: p0_i, a90: p90_i,
                  a180: p180_i, a270: p270_i};
      for (int i = 1; i < INTERP_LAT; i++) begin
         dl_d[i] = dl_q[i-1];
      end
   end

   assign tap = dl_q[INTERP_LAT-1];

   // Neighbour index k doubles as the code bit position (k*45 degrees)
   always_comb begin
      sa_vld_d   = tap.vld;
      sa_ctr_d   = tap.ctr;
      sa_nb_d    = '0;
      sa_nb_d[0] = tap.a0;
      sa_nb_d[1] = round_sat(i45_i);
      sa_nb_d[2] = tap.a90;
      sa_nb_d[3] = round_sat(i135_i);
      sa_nb_d[4] = tap.a180;
      sa_nb_d[5] = round_sat(i225_i);
      sa_nb_d[6] = tap.a270;
      sa_nb_d[7] = round_sat(i315_i);
   end

   always_comb begin
      code_d  = code_q;
      valid_d = sa_vld_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (sa_vld_q) begin
         for (int k = 0; k < 8; k++) begin
            code_d[k] = (sa_nb_q[k] >= sa_ctr_q);
         end
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < INTERP_LAT; i++) begin
            dl_q[i] <= '0;
         end
         sa_vld_q <= 1'b0;
         sa_ctr_q <= '0;
         sa_nb_q  <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         for (int i = 0; i < INTERP_LAT; i++) begin
            dl_q[i] <= dl_d[i];
         end
         sa_vld_q <= sa_vld_d;
         sa_ctr_q <= sa_ctr_d;
         sa_nb_q  <= sa_nb_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
      end
   end

   assign code_o  = code_q;
   assign valid_o = valid_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_lbp_code_gen.sv
// Scoreboard bench for lbp_code_gen: stimulus pushes expected codes, a
// negedge monitor pops and checks code, done flag and latency.
module tb_lbp_code_gen;

   localparam int L    = 3;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [7:0]  center_i, p0_i, p90_i, p180_i, p270_i;
   logic [23:0] i45_i, i135_i, i225_i, i315_i;
   logic [7:0]  code_o;
   logic        valid_o, done_o;

   lbp_code_gen #(.INTERP_LAT(L), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .center_i(center_i),
      .p0_i(p0_i), .p90_i(p90_i), .p180_i(p180_i), .p270_i(p270_i),
      .i45_i(i45_i), .i135_i(i135_i), .i225_i(i225_i), .i315_i(i315_i),
      .code_o(code_o), .valid_o(valid_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] code;
      logic       done;
      int         issue;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int frame_cnt = 0;
   logic [23:0] p45[0:L], p135[0:L], p225[0:L], p315[0:L];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
      end
   endtask

   // One clock slot; diagonals issued now reach the DUT L slots later.
   task automatic step(input logic v, input logic [7:0] c, a0, a90, a180, a270,
                       input logic [23:0] d45, d135, d225, d315, input logic [7:0] ex);
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = L; i > 0; i--) begin
         p45[i] = p45[i-1]; p135[i] = p135[i-1];
         p225[i] = p225[i-1]; p315[i] = p315[i-1];
      end
      p45[0] = d45; p135[0] = d135; p225[0] = d225; p315[0] = d315;
      valid_i = v; center_i = c;
      p0_i = a0; p90_i = a90; p180_i = a180; p270_i = a270;
      i45_i = p45[L]; i135_i = p135[L]; i225_i = p225[L]; i315_i = p315[L];
      if (v) begin
         e.code  = ex;
         e.done  = (frame_cnt == NPIX - 1);
         e.issue = cyc;
         exp_q.push_back(e);
         frame_cnt = e.done ? 0 : frame_cnt + 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 24'd0, 24'd0, 24'd0, 24'd0, 8'd0);
   endtask

   function automatic logic [7:0] ax(input logic b);
      return b ? 8'd128 : 8'd127;
   endfunction

   function automatic logic [23:0] dg(input logic b);
      return b ? 24'h7F8000 : 24'h7F7FFF;
   endfunction

   // Centre 128; each neighbour sits just at/just below the threshold per bit of k
   task automatic pix(input logic [7:0] k);
      step(1'b1, 8'd128, ax(k[0]), ax(k[2]), ax(k[4]), ax(k[6]),
           dg(k[1]), dg(k[3]), dg(k[5]), dg(k[7]), k);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst = 1'b1;
      valid_i = 1'b0;
      exp_q.delete();
      frame_cnt = 0;
      for (int i = 0; i <= L; i++) begin
         p45[i] = '0; p135[i] = '0; p225[i] = '0; p315[i] = '0;
      end
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset code_o", code_o, 8'h00);
      chk("reset valid_o", valid_o, 1'b0);
      chk("reset done_o", done_o, 1'b0);
   endtask

   // Monitor
   initial begin
      logic [7:0] last_code;
      exp_t e;
      last_code = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_code = 8'h00;
         end else if (valid_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected valid_o", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("code_o", code_o, e.code);
               chk("done_o", done_o, e.done);
               chk("latency", cyc - e.issue, L + 2);
               last_code = e.code;
            end
         end else begin
            chk("code hold", code_o, last_code);
            chk("done idle", done_o, 1'b0);
         end
      end
   end

   logic [9:0]  stream_pat;
   logic [7:0]  frame_codes[16];
   int          oh;

   initial begin
      rst = 1'b1; valid_i = 1'b0; center_i = '0;
      p0_i = '0; p90_i = '0; p180_i = '0; p270_i = '0;
      i45_i = '0; i135_i = '0; i225_i = '0; i315_i = '0;
      do_reset(3);

      // alignment
      step(1'b1, 8'd100, 8'd101, 8'd99, 8'd100, 8'd50,
           24'h650000, 24'h630000, 24'h640000, 24'h000000, 8'h33);
      idle(6);

      // rounding boundary on the 45-degree sample
      step(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
           24'h637FFF, 24'h640000, 24'h640000, 24'h640000, 8'hFD);
      step(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
           24'h638000, 24'h640000, 24'h640000, 24'h640000, 8'hFF);

      // saturation and small-value rounding
      step(1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
           24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 8'hFF);
      step(1'b1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0,
           24'h00FF80, 24'h00FF80, 24'h00FF80, 24'h00FF80, 8'hAA);

      // zero centre
      step(1'b1, 8'd0, 8'd0, 8'd3, 8'd200, 8'd255,
           24'h000000, 24'h007FFF, 24'hFFFFFF, 24'h123456, 8'hFF);
      idle(2);

      // streaming with bubbles, one-hot codes pin the bit order
      stream_pat = 10'b1101101111;
      oh = 0;
      for (int s = 9; s >= 0; s--) begin
         if (stream_pat[s]) begin
            pix(8'(1 << oh));
            oh++;
         end else begin
            idle(1);
         end
      end
      idle(8);

      // reset with three pixels in flight
      pix(8'h5A);
      pix(8'hC3);
      pix(8'h0F);
      idle(1);
      do_reset(1);

      // two full frames after reset
      frame_codes = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h00, 8'hFF,
                      8'h81, 8'h7E, 8'h11, 8'hEE, 8'h24, 8'hDB, 8'h99, 8'h66};
      for (int i = 0; i < 16; i++) begin
         pix(frame_codes[i]);
         if (i == 11) idle(2);
      end
      idle(L + 6);

      chk("scoreboard drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no end, required end");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
